// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
// Shares one external SPI RAM between two word-access requesters. Each
// granted request becomes one SPI transaction: command byte (0x03 read,
// 0x02 write), ADDR_BITS address bits (MSB first), then a 32-bit data word
// sent or received little-endian by byte, each byte MSB first.
// Requests are sampled only in IDLE; ties are broken round-robin.
//
// Handshake: a port raises reqN_valid together with its write/addr/wdata
// fields and keeps it high until doneN pulses for one cycle. The fields are
// latched at grant, so the request may be dropped after grant; the
// transaction still completes and doneN still pulses. A request that is
// seen while busy is considered in the next IDLE cycle.
//
// Ports:
//   clk, rstn                      system clock, async active-low reset
//   req{0,1}_valid/_write/_addr/_wdata   per-port request
//   done0, done1                   one-cycle completion pulses
//   rdata                          last read word (valid in done cycle, held)
//   busy                           high whenever the FSM is not in IDLE
//   spi_select/spi_clk/spi_mosi    registered SPI outputs (mode 0, clk/2)
//   spi_miso                       serial data from the RAM
//   dbg_state                      current FSM state
module spi_ram_arbiter #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [31:0]          req0_wdata,
  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [31:0]          req1_wdata,
  output logic                 done0,
  output logic                 done1,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 spi_select,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // Whole transaction is shifted out of one register: cmd, addr, data.
  localparam int SRW = 8 + ADDR_BITS + 32;
  localparam int CW  = $clog2(SRW);
  localparam logic [CW-1:0] CMD_LAST  = CW'(7);
  localparam logic [CW-1:0] ADDR_LAST = CW'(8 + ADDR_BITS - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(SRW - 1);

  logic [2:0]     state;
  logic           last;     // port granted most recently
  logic           gnt;      // port owning the running transaction
  logic           wr;       // running transaction is a write
  logic           phase;    // 0: spi_clk low half of a bit, 1: high half
  logic [CW-1:0]  bit_cnt;  // index of the bit currently on the wire
  logic [SRW-1:0] tx_sr;    // bits still to be sent, next bit at MSB
  logic [30:0]    rx_sr;    // bits received so far (last bit joins on the final edge)

  // Arbitration: on a tie grant the port not granted last time.
  logic                 pick;
  logic                 any_req;
  logic                 sel_write;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [31:0]          sel_wdata;
  logic [SRW-1:0]       tx_load;
  logic [31:0]          rx_word;

  always_comb begin
    pick = req1_valid;
    if (req0_valid && req1_valid) begin
      pick = ~last;
    end
  end

  assign any_req   = req0_valid | req1_valid;
  assign sel_write = pick ? req1_write : req0_write;
  assign sel_addr  = pick ? req1_addr  : req0_addr;
  assign sel_wdata = pick ? req1_wdata : req0_wdata;

  // Data bytes go out lowest byte first; reads send zeros in the data phase.
  assign tx_load = {(sel_write ? 8'h02 : 8'h03),
                    sel_addr,
                    (sel_write ? {sel_wdata[7:0], sel_wdata[15:8],
                                  sel_wdata[23:16], sel_wdata[31:24]}
                               : 32'h0)};

  // First received byte sits in the top of the shift register; it belongs
  // in rdata[7:0].
  logic [31:0] rx_full;
  assign rx_full = {rx_sr, spi_miso};
  assign rx_word = {rx_full[7:0], rx_full[15:8], rx_full[23:16], rx_full[31:24]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      last       <= 1'b1;
      gnt        <= 1'b0;
      wr         <= 1'b0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= 32'h0;
      spi_select <= 1'b1;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt        <= pick;
            last       <= pick;
            wr         <= sel_write;
            spi_select <= 1'b0;
            spi_clk    <= 1'b0;
            spi_mosi   <= tx_load[SRW-1];
            tx_sr      <= {tx_load[SRW-2:0], 1'b0};
            phase      <= 1'b0;
            bit_cnt    <= '0;
            state      <= S_CMD;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (!phase) begin
            spi_clk <= 1'b1;
            phase   <= 1'b1;
          end else begin
            // Edge ending the high half: sample MISO, start the next bit.
            spi_clk <= 1'b0;
            phase   <= 1'b0;
            rx_sr   <= {rx_sr[29:0], spi_miso};
            if (bit_cnt == BIT_LAST) begin
              state      <= S_GAP;
              spi_select <= 1'b1;
              spi_mosi   <= 1'b0;
              done0      <= ~gnt;
              done1      <= gnt;
              if (!wr) begin
                rdata <= rx_word;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              spi_mosi <= tx_sr[SRW-1];
              tx_sr    <= {tx_sr[SRW-2:0], 1'b0};
              if (bit_cnt == CMD_LAST) begin
                state <= S_ADDR;
              end else if (bit_cnt == ADDR_LAST) begin
                state <= S_DATA;
              end
            end
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
